cpu64_l1_probe_unit: RTL
========================

CPU64_L1_PROBE_UNIT -- requirements
Module: cpu64_l1_probe_unit

Interface
REQ-001 SHALL have parameters: ADDR_W, default 64, address width; SOURCE_W, default 6, TileLink source width; DATA_W, default 64, beat width; BEATS, default 8, beats per line.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset; asynchronous, active-low
- b_valid_i/b_ready_o  in/out  1  B-channel Probe handshake
- b_param_i  in  2  cap: toT=0, toB=1, toN=2
- b_addr_i  in  ADDR_W  line address
- b_source_i  in  SOURCE_W  probe source
- tag_req_o  out  1  tag lookup strobe
- tag_addr_o  out  ADDR_W  lookup address
- tag_hit_i  in  1  lookup hit, valid the cycle after tag_req_o
- tag_state_i  in  2  N=0, B=1, T=2, same timing as tag_hit_i
- tag_dirty_i  in  1  dirty, same timing as tag_hit_i
- tag_wr_o  out  1  state update strobe
- tag_wstate_o  out  2  new state
- tag_wdirty_o  out  1  new dirty bit
- data_req_o  out  1  data array read strobe
- data_beat_o  out  $clog2(BEATS)  beat index
- data_rdata_i  in  DATA_W  read data, valid the cycle after data_req_o
- c_valid_o/c_ready_i  out/in  1  C-channel handshake
- c_opcode_o  out  3  ProbeAck=4, ProbeAckData=5
- c_param_o  out  3  TtoB=0, TtoN=1, BtoN=2, TtoT=3, BtoB=4, NtoN=5
- c_addr_o  out  ADDR_W  echoed address
- c_source_o  out  SOURCE_W  echoed source
- c_data_o  out  DATA_W  beat data
- c_last_o  out  1  final beat of the response
- busy_o  out  1  probe in flight
- conflict_i  in  1  L1 MSHR holds the same line (see REQ-021)

Function
REQ-003 SHALL use FSM states IDLE, LOOKUP, DECIDE, READ, SEND, ACK, UPDATE.
REQ-004 SHALL assert b_ready_o only in IDLE; b_valid_i && b_ready_o captures param, address and source and moves to LOOKUP.
REQ-005 LOOKUP SHALL pulse tag_req_o for one cycle with the captured address, then go to DECIDE.
REQ-006 DECIDE SHALL sample the tag response and choose the response. Miss or N: ProbeAck NtoN, no update. B with cap toN: ProbeAck BtoN, new state N. B with any other cap: ProbeAck BtoB, no update. T with cap toT: ProbeAck TtoT, no update. T clean with cap toB or toN: ProbeAck TtoB or TtoN. T dirty with cap toB or toN: ProbeAckData TtoB or TtoN, new dirty 0.
REQ-007 ProbeAckData SHALL go through READ then SEND for each beat, in index order 0..BEATS-1. READ pulses data_req_o; SEND holds c_valid_o with the registered data_rdata_i until c_ready_i.
REQ-008 c_last_o SHALL be 1 only on beat BEATS-1; a ProbeAck without data SHALL be a single ACK beat with c_last_o=1.
REQ-009 All C-channel outputs SHALL stay stable while c_valid_o && !c_ready_i.
REQ-010 After the last C handshake, the FSM SHALL go to UPDATE, pulse tag_wr_o for one cycle only if the state changes, then return to IDLE.
REQ-011 Minimum latency from B accept to c_valid_o SHALL be 3 cycles for ProbeAck and 4 cycles for ProbeAckData.
REQ-012 The beat counter SHALL wrap to 0 after beat BEATS-1.
REQ-013 busy_o SHALL be 1 in every state except IDLE.
REQ-014 A new probe SHALL NOT be accepted until UPDATE completes; only one probe is in flight at a time.

Reset
REQ-015 While rst_n=0, the FSM SHALL be in IDLE and all captured registers and the beat counter SHALL be 0.
REQ-016 During reset, every output SHALL be 0, except b_ready_o, which SHALL be 1 after deassertion.
REQ-017 Reset asserted mid-response SHALL abandon the probe; no tag_wr_o is issued.

Configuration
REQ-018 Macro CPU64_L1_PROBE_CONFLICT_EN SHALL control conflict stalling.
REQ-019 With the macro defined, conflict_i=1 SHALL hold the FSM in LOOKUP (no tag_req_o) until it deasserts.
REQ-020 Without the macro, conflict_i SHALL be ignored and the FSM SHALL proceed as in REQ-005.
REQ-021 conflict_i is the only port affected by the macro; it SHALL exist in both builds.

Structure
REQ-022 Opcode, cap, report-param and line-state encodings SHALL reside in shared package cpu64_tl_pkg.
REQ-023 The REQ-006 table SHALL be a combinational sub-module cpu64_l1_probe_decide.

Verification
REQ-024 T dirty, cap toN=2 -> 8 beats of opcode 5, param 1, c_last_o=1 on beat 7; then tag_wr_o with state 0, dirty 0.
REQ-025 B, cap toB=1 -> one beat of opcode 4, param 4 (BtoB); no tag_wr_o.
REQ-026 Miss -> opcode 4, param 5 (NtoN), 3 cycles after B accept.
REQ-027 c_ready_i held 0 for 5 cycles on beat 3 -> beat 3 data, address and source stable; beat 4 follows.
REQ-028 With the macro defined, conflict_i=1 for 4 cycles -> tag_req_o delayed 4 cycles; without the macro -> no delay.
REQ-029 rst_n pulsed during beat 2 -> all outputs 0, no tag_wr_o; the next probe completes normally.

Source files
------------

// File: rtl/cpu64_tl_pkg.sv
// Shared TileLink encodings for the L1 probe path: probe caps, line states,
// C-channel opcodes, probe report params and the probe decision record.
package cpu64_tl_pkg;

    // Permission cap carried by a B-channel Probe.
    typedef enum logic [1:0] {
        CAP_TO_T = 2'd0,
        CAP_TO_B = 2'd1,
        CAP_TO_N = 2'd2
    } cap_e;

    // Coherence state of an L1 line as held in the tag array.
    typedef enum logic [1:0] {
        LINE_N = 2'd0,
        LINE_B = 2'd1,
        LINE_T = 2'd2
    } line_state_e;

    // C-channel opcodes used to answer a probe.
    typedef enum logic [2:0] {
        OP_PROBE_ACK      = 3'd4,
        OP_PROBE_ACK_DATA = 3'd5
    } c_opcode_e;

    // Report params: the permission transition the L1 performed.
    typedef enum logic [2:0] {
        REP_T_TO_B = 3'd0,
        REP_T_TO_N = 3'd1,
        REP_B_TO_N = 3'd2,
        REP_T_TO_T = 3'd3,
        REP_B_TO_B = 3'd4,
        REP_N_TO_N = 3'd5
    } report_e;

    // Everything the FSM needs to know once the tag lookup is back.
    typedef struct packed {
        logic       with_data;  // dirty line: answer with ProbeAckData
        logic [2:0] opcode;
        logic [2:0] param;
        logic       update;     // line state changes, write the tag back
        logic [1:0] new_state;
        logic       new_dirty;
    } probe_resp_t;

endpackage

// File: rtl/cpu64_l1_probe_decide.sv
// Combinational probe decision: maps the tag lookup result and the probe cap
// onto the response opcode/param and the tag write-back, if any.
module cpu64_l1_probe_decide
    import cpu64_tl_pkg::*;
(
    input  logic        hit,
    input  logic [1:0]  line_state,
    input  logic        dirty,
    input  logic [1:0]  cap,
    output probe_resp_t resp
);

    // Decision table; a miss and an N line both report NtoN.
    always_comb begin
        // NOTE: every field gets a default first so this block can never infer a latch.
        resp           = '0;
        resp.opcode    = OP_PROBE_ACK;
        resp.param     = REP_N_TO_N;
        resp.new_state = LINE_N;

        if (hit && line_state == LINE_B) begin
            if (cap == CAP_TO_N) begin
                resp.param     = REP_B_TO_N;
                resp.update    = 1'b1;
                resp.new_state = LINE_N;
            end else begin
                resp.param     = REP_B_TO_B;
            end
        end else if (hit && line_state == LINE_T) begin
            if (cap == CAP_TO_B || cap == CAP_TO_N) begin
                resp.param     = (cap == CAP_TO_B) ? REP_T_TO_B : REP_T_TO_N;
                resp.update    = 1'b1;
                resp.new_state = (cap == CAP_TO_B) ? LINE_B : LINE_N;
                resp.new_dirty = 1'b0;
                if (dirty) begin
                    resp.with_data = 1'b1;
                    resp.opcode    = OP_PROBE_ACK_DATA;
                end
            end else begin
                resp.param     = REP_T_TO_T;
            end
        end
    end

endmodule

// File: rtl/cpu64_l1_probe_unit.sv
// L1 probe unit: accepts one TileLink B-channel Probe at a time, looks up the
// tag array, answers on the C channel (ProbeAck or a full-line ProbeAckData)
// and writes back the downgraded tag state.
// Build option: define CPU64_L1_PROBE_CONFLICT_EN to stall the tag lookup
// while conflict_i reports that the L1 MSHR owns the same line.
module cpu64_l1_probe_unit
    import cpu64_tl_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int DATA_W   = 64,
    parameter int BEATS    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic [1:0]               b_param_i,
    input  logic [ADDR_W-1:0]        b_addr_i,
    input  logic [SOURCE_W-1:0]      b_source_i,
    output logic                     tag_req_o,
    output logic [ADDR_W-1:0]        tag_addr_o,
    input  logic                     tag_hit_i,
    input  logic [1:0]               tag_state_i,
    input  logic                     tag_dirty_i,
    output logic                     tag_wr_o,
    output logic [1:0]               tag_wstate_o,
    output logic                     tag_wdirty_o,
    output logic                     data_req_o,
    output logic [$clog2(BEATS)-1:0] data_beat_o,
    input  logic [DATA_W-1:0]        data_rdata_i,
    output logic                     c_valid_o,
    input  logic                     c_ready_i,
    output logic [2:0]               c_opcode_o,
    output logic [2:0]               c_param_o,
    output logic [ADDR_W-1:0]        c_addr_o,
    output logic [SOURCE_W-1:0]      c_source_o,
    output logic [DATA_W-1:0]        c_data_o,
    output logic                     c_last_o,
    output logic                     busy_o,
    input  logic                     conflict_i
);

    // BEATS is expected to be a power of two of at least 2.
    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, DECIDE, READ, SEND, ACK, UPDATE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          cap_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SOURCE_W-1:0] source_q;
    logic [BEAT_W-1:0]   beat_q;
    probe_resp_t         resp_d, resp_q;
    logic [DATA_W-1:0]   data_q;
    logic                hold_q;   // data_q holds the beat while C is stalled
    logic                rdy_q;    // keeps b_ready_o low until reset is released
    logic                accept;
    logic                stall;
    logic                last_beat;

`ifdef CPU64_L1_PROBE_CONFLICT_EN
    assign stall = conflict_i;
`else
    logic unused_conflict;
    assign unused_conflict = conflict_i;
    assign stall           = 1'b0;
`endif

    cpu64_l1_probe_decide u_decide (
        .hit        (tag_hit_i),
        .line_state (tag_state_i),
        .dirty      (tag_dirty_i),
        .cap        (cap_q),
        .resp       (resp_d)
    );

    assign b_ready_o    = (state_q == IDLE) && rdy_q;
    assign accept       = b_valid_i && b_ready_o;
    assign busy_o       = (state_q != IDLE);
    assign last_beat    = (beat_q == LAST_BEAT);
    assign tag_addr_o   = addr_q;
    assign tag_wstate_o = resp_q.new_state;
    assign tag_wdirty_o = resp_q.new_dirty;
    assign data_beat_o  = beat_q;
    assign c_opcode_o   = resp_q.opcode;
    assign c_param_o    = resp_q.param;
    assign c_addr_o     = addr_q;
    assign c_source_o   = source_q;

    // Next-state selection and the per-state strobes.
    always_comb begin
        state_d    = state_q;
        tag_req_o  = 1'b0;
        tag_wr_o   = 1'b0;
        data_req_o = 1'b0;
        c_valid_o  = 1'b0;
        c_last_o   = 1'b0;
        c_data_o   = '0;

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = LOOKUP;
            end
            LOOKUP: begin
                if (!stall) begin
                    tag_req_o = 1'b1;
                    state_d   = DECIDE;
                end
            end
            DECIDE: begin
                state_d = resp_d.with_data ? READ : ACK;
            end
            READ: begin
                data_req_o = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                c_valid_o = 1'b1;
                c_last_o  = last_beat;
                // The array only drives read data for one cycle; afterwards
                // the captured copy keeps the beat stable under backpressure.
                if (resp_q.with_data) c_data_o = hold_q ? data_q : data_rdata_i;
                if (c_ready_i) state_d = last_beat ? UPDATE : READ;
            end
            ACK: begin
                c_valid_o = 1'b1;
                c_last_o  = 1'b1;
                if (c_ready_i) state_d = UPDATE;
            end
            UPDATE: begin
                tag_wr_o = resp_q.update;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; reset abandons any probe in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Probe capture, decision register, beat counter and beat data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            cap_q    <= '0;
            addr_q   <= '0;
            source_q <= '0;
            beat_q   <= '0;
            resp_q   <= '0;
            data_q   <= '0;
            hold_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cap_q    <= b_param_i;
                        addr_q   <= b_addr_i;
                        source_q <= b_source_i;
                    end
                end
                DECIDE: begin
                    resp_q <= resp_d;
                    beat_q <= '0;
                end
                SEND: begin
                    if (c_ready_i) begin
                        hold_q <= 1'b0;
                        beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
                    end else if (!hold_q) begin
                        hold_q <= 1'b1;
                        data_q <= data_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
